ysyx_22040127_fetch: RTL and testbench

YSYX_22040127_FETCH -- requirements
Module: ysyx_22040127_fetch

---
 rtl/ysyx_22040127_fetch_pkg.sv | 23 ++
 rtl/ysyx_22040127_fetch.sv | 111 +++++++++++
 tb/tb_ysyx_22040127_fetch.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040127_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// bus width, default boot address and small address helpers.
package ysyx_22040127_fetch_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int unsigned IF_TO_ID_WIDTH = 64;

    localparam logic [31:0] FETCH_RESET_PC = 32'h8000_0000;

    // Sequential next pc; wraps naturally at 2^32.
    function automatic logic [31:0] fetch_next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] fetch_align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ysyx_22040127_fetch.sv
// Instruction-fetch stage: one outstanding request to instruction memory,
// registered hand-off to decode, and redirect handling that cancels any
// response already in flight.
module ysyx_22040127_fetch
    import ysyx_22040127_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_allowin,
    output logic                      if_to_id_valid,
    output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus,
    input  logic                      br_taken,
    input  logic [31:0]               br_target,
    output logic                      imem_req,
    output logic [31:0]               imem_addr,
    input  logic                      imem_addr_ok,
    input  logic                      imem_data_ok,
    input  logic [31:0]               imem_rdata
);

    logic [1:0]                state_q, state_d;
    logic [31:0]               pc_q, pc_d;
    logic                      cancel_q, cancel_d;
    logic [IF_TO_ID_WIDTH-1:0] bus_q, bus_d;

    logic        redirect;
    logic [31:0] redirect_pc;

    // A branch only counts when decode is actually consuming its instruction.
    assign redirect    = br_taken & id_allowin;
    assign redirect_pc = fetch_align_word(br_target);

    // Next-state logic; a redirect outranks every other transition.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cancel_d = cancel_q;
        bus_d    = bus_q;
        case (state_q)
            S_REQ: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_addr_ok) begin
                        // The old address was accepted; its data must be dropped.
                        cancel_d = 1'b1;
                        state_d  = S_WAIT;
                    end
                end else if (imem_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (imem_data_ok) begin
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        cancel_d = 1'b1;
                    end
                end else if (imem_data_ok) begin
                    if (cancel_q) begin
                        // Stale response: pc already points at the redirect target.
                        cancel_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        bus_d   = {imem_rdata, pc_q};
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (id_allowin) begin
                    pc_d    = fetch_next_pc(pc_q);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d  = S_REQ;
                cancel_d = 1'b0;
            end
        endcase
    end

    // State, pc, cancel flag and output register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC;
            cancel_q <= 1'b0;
            bus_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cancel_q <= cancel_d;
            bus_q    <= bus_d;
        end
    end

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    // The held instruction is withdrawn in the cycle decode redirects.
    assign if_to_id_valid = (state_q == S_HOLD) & ~redirect;
    assign if_to_id_bus   = bus_q;

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Directed bench for ysyx_22040127_fetch: a default-reset instance and a
// second instance booting at the top of the address space.
module tb_ysyx_22040127_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_addr_ok;
    logic        imem_data_ok;
    logic [31:0] imem_rdata;

    logic        a_valid, b_valid;
    logic [63:0] a_bus, b_bus;
    logic        a_req, b_req;
    logic [31:0] a_addr, b_addr;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ysyx_22040127_fetch u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .id_allowin     (id_allowin),
        .if_to_id_valid (a_valid),
        .if_to_id_bus   (a_bus),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req       (a_req),
        .imem_addr      (a_addr),
        .imem_addr_ok   (imem_addr_ok),
        .imem_data_ok   (imem_data_ok),
        .imem_rdata     (imem_rdata)
    );

    ysyx_22040127_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .id_allowin     (id_allowin),
        .if_to_id_valid (b_valid),
        .if_to_id_bus   (b_bus),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req       (b_req),
        .imem_addr      (b_addr),
        .imem_addr_ok   (imem_addr_ok),
        .imem_data_ok   (imem_data_ok),
        .imem_rdata     (imem_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        id_allowin   = 1'b0;
        br_taken     = 1'b0;
        br_target    = 32'h0;
        imem_addr_ok = 1'b0;
        imem_data_ok = 1'b0;
        imem_rdata   = 32'h0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL reset_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0000) begin errs++; $display("FAIL reset_addr: got %h want 80000000", a_addr); end
        vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", a_valid); end
        vec++; if (a_bus !== 64'h0) begin errs++; $display("FAIL reset_bus: got %h want 0", a_bus); end
        vec++; if (b_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL reset_addr_b: got %h want fffffffc", b_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] exp;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp = 32'h8000_0000 + 32'(4 * k);
            imem_addr_ok = 1'b1;
            vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL stream_req%0d: got %b want 1", k, a_req); end
            vec++; if (a_addr !== exp) begin errs++; $display("FAIL stream_addr%0d: got %h want %h", k, a_addr, exp); end
            tick();
            imem_addr_ok = 1'b0;
            imem_data_ok = 1'b1;
            imem_rdata   = 32'h0000_0013;
            vec++; if (a_req !== 1'b0) begin errs++; $display("FAIL stream_wait_req%0d: got %b want 0", k, a_req); end
            vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL stream_wait_valid%0d: got %b want 0", k, a_valid); end
            tick();
            imem_data_ok = 1'b0;
            vec++; if (a_valid !== 1'b1) begin errs++; $display("FAIL stream_valid%0d: got %b want 1", k, a_valid); end
            vec++; if (a_bus !== {32'h0000_0013, exp}) begin errs++; $display("FAIL stream_bus%0d: got %h want %h", k, a_bus, {32'h0000_0013, exp}); end
            id_allowin = 1'b1;
            tick();
            id_allowin = 1'b0;
        end
        vec++; if (a_addr !== 32'h8000_000C) begin errs++; $display("FAIL stream_next_addr: got %h want 8000000c", a_addr); end
    endtask

    task automatic test_stall;
        do_reset();
        imem_addr_ok = 1'b1;
        tick();
        imem_addr_ok = 1'b0;
        imem_data_ok = 1'b1;
        imem_rdata   = 32'h0000_0093;
        tick();
        imem_data_ok = 1'b0;
        for (int k = 0; k < 5; k++) begin
            vec++; if (a_valid !== 1'b1) begin errs++; $display("FAIL stall_valid%0d: got %b want 1", k, a_valid); end
            vec++; if (a_bus !== 64'h0000_0093_8000_0000) begin errs++; $display("FAIL stall_bus%0d: got %h want 0000009380000000", k, a_bus); end
            vec++; if (a_req !== 1'b0) begin errs++; $display("FAIL stall_req%0d: got %b want 0", k, a_req); end
            tick();
        end
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL stall_resume_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0004) begin errs++; $display("FAIL stall_resume_addr: got %h want 80000004", a_addr); end
    endtask

    task automatic test_redirect_wait;
        do_reset();
        imem_addr_ok = 1'b1;
        tick();
        imem_addr_ok = 1'b0;
        br_taken     = 1'b1;
        id_allowin   = 1'b1;
        br_target    = 32'h8000_0100;
        tick();
        idle_inputs();
        vec++; if (a_req !== 1'b0) begin errs++; $display("FAIL rdw_still_wait: got req %b want 0", a_req); end
        tick();
        imem_data_ok = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        tick();
        imem_data_ok = 1'b0;
        vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL rdw_valid: got %b want 0", a_valid); end
        vec++; if (a_bus !== 64'h0) begin errs++; $display("FAIL rdw_bus: got %h want 0", a_bus); end
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL rdw_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0100) begin errs++; $display("FAIL rdw_addr: got %h want 80000100", a_addr); end
    endtask

    task automatic test_redirect_dataok;
        do_reset();
        imem_addr_ok = 1'b1;
        tick();
        imem_addr_ok = 1'b0;
        imem_data_ok = 1'b1;
        imem_rdata   = 32'h1234_5678;
        br_taken     = 1'b1;
        id_allowin   = 1'b1;
        br_target    = 32'h8000_0203;
        tick();
        idle_inputs();
        vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL rdo_valid: got %b want 0", a_valid); end
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL rdo_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0200) begin errs++; $display("FAIL rdo_addr: got %h want 80000200", a_addr); end
        imem_addr_ok = 1'b1;
        tick();
        imem_addr_ok = 1'b0;
        imem_data_ok = 1'b1;
        imem_rdata   = 32'h0000_0013;
        tick();
        imem_data_ok = 1'b0;
        vec++; if (a_bus !== 64'h0000_0013_8000_0200) begin errs++; $display("FAIL rdo_bus: got %h want 0000001380000200", a_bus); end
    endtask

    // Continues from the S_HOLD state left by test_redirect_dataok.
    task automatic test_branch_no_allowin;
        br_taken  = 1'b1;
        br_target = 32'h8000_0400;
        for (int k = 0; k < 4; k++) begin
            #1;
            vec++; if (a_valid !== 1'b1) begin errs++; $display("FAIL bna_valid%0d: got %b want 1", k, a_valid); end
            vec++; if (a_req !== 1'b0) begin errs++; $display("FAIL bna_req%0d: got %b want 0", k, a_req); end
            tick();
        end
        id_allowin = 1'b1;
        #1;
        vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL bna_suppress: got %b want 0", a_valid); end
        tick();
        idle_inputs();
        vec++; if (a_addr !== 32'h8000_0400) begin errs++; $display("FAIL bna_addr: got %h want 80000400", a_addr); end
        tick();
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL bna_hold_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0400) begin errs++; $display("FAIL bna_hold_addr: got %h want 80000400", a_addr); end
    endtask

    // Continues in S_REQ at 0x80000400.
    task automatic test_redirect_req;
        br_taken   = 1'b1;
        id_allowin = 1'b1;
        br_target  = 32'h8000_0500;
        tick();
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL rrq_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0500) begin errs++; $display("FAIL rrq_addr: got %h want 80000500", a_addr); end
        br_target    = 32'h8000_0600;
        imem_addr_ok = 1'b1;
        tick();
        idle_inputs();
        vec++; if (a_req !== 1'b0) begin errs++; $display("FAIL rrq_wait_req: got %b want 0", a_req); end
        imem_data_ok = 1'b1;
        imem_rdata   = 32'hCAFE_F00D;
        tick();
        imem_data_ok = 1'b0;
        vec++; if (a_valid !== 1'b0) begin errs++; $display("FAIL rrq_drop_valid: got %b want 0", a_valid); end
        vec++; if (a_req !== 1'b1) begin errs++; $display("FAIL rrq_drop_req: got %b want 1", a_req); end
        vec++; if (a_addr !== 32'h8000_0600) begin errs++; $display("FAIL rrq_drop_addr: got %h want 80000600", a_addr); end
    endtask

    task automatic test_wrap_and_reset;
        do_reset();
        imem_addr_ok = 1'b1;
        tick();
        imem_addr_ok = 1'b0;
        imem_data_ok = 1'b1;
        imem_rdata   = 32'h0000_0013;
        tick();
        imem_data_ok = 1'b0;
        vec++; if (b_bus !== 64'h0000_0013_FFFF_FFFC) begin errs++; $display("FAIL wrap_bus: got %h want 00000013fffffffc", b_bus); end
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        vec++; if (b_addr !== 32'h0000_0000) begin errs++; $display("FAIL wrap_addr: got %h want 00000000", b_addr); end
        imem_addr_ok = 1'b1;
        tick();
        imem_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vec++; if (b_req !== 1'b1) begin errs++; $display("FAIL mrst_req: got %b want 1", b_req); end
        vec++; if (b_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL mrst_addr: got %h want fffffffc", b_addr); end
        imem_data_ok = 1'b1;
        imem_rdata   = 32'h0BAD_0BAD;
        tick();
        imem_data_ok = 1'b0;
        vec++; if (b_valid !== 1'b0) begin errs++; $display("FAIL mrst_late_valid: got %b want 0", b_valid); end
        vec++; if (b_req !== 1'b1) begin errs++; $display("FAIL mrst_late_req: got %b want 1", b_req); end
        vec++; if (b_bus !== 64'h0) begin errs++; $display("FAIL mrst_late_bus: got %h want 0", b_bus); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_dataok();
        test_branch_no_allowin();
        test_redirect_req();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
